sccb_arbiter: RTL
=================

SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 SHALL provide parameter NREQ, default 3, number of requesters sharing one SCCB write engine.
REQ-002 SHALL provide parameter RETRY_MAX, default 3, re-issues of a NACKed transfer before failure.
REQ-003 SHALL provide parameter TIMEOUT, default 50000, clk cycles allowed from engine enable to eng_finished.
REQ-004 SHALL have port: clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: req  input  NREQ  per-requester transfer request, level, held until done or err.
REQ-007 SHALL have port: req_data  input  24*NREQ  per-requester {dev_addr, reg_addr, reg_data}, slice i = bits 24i+23:24i.
REQ-008 SHALL have port: gnt  output  NREQ  one-hot grant, at most one bit set.
REQ-009 SHALL have port: done  output  NREQ  one-cycle pulse, transfer ACKed.
REQ-010 SHALL have port: err  output  NREQ  one-cycle pulse, retries exhausted or timeout.
REQ-011 SHALL have port: eng_tick  input  1  one-cycle bus-clock negedge strobe from the SCCB clock divider.
REQ-012 SHALL have port: eng_en  output  1  engine enable.
REQ-013 SHALL have port: eng_data  output  24  word to the engine.
REQ-014 SHALL have port: eng_finished  input  1  engine transfer complete, level.
REQ-015 SHALL have port: eng_ack  input  1  engine ack bit; 0 = slave ACK, 1 = NACK; valid while eng_finished=1.
REQ-016 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, GRANT, ISSUE, WAIT, GAP.
REQ-018 IDLE: when any req bit is high, SHALL select winner round-robin starting after the last granted index, set gnt one-hot, latch req_data slice into eng_data, clear retry counter, go to GRANT.
REQ-019 GRANT -> ISSUE on next eng_tick; all eng_en changes SHALL occur only in cycles where eng_tick=1.
REQ-020 ISSUE: SHALL assert eng_en on that tick, clear timeout counter, go to WAIT.
REQ-021 WAIT: on eng_tick with eng_finished=1 SHALL deassert eng_en; eng_ack=0 -> pulse done[winner], go to GAP; eng_ack=1 and retries<RETRY_MAX -> increment retries, go to ISSUE; else pulse err[winner], go to GAP.
REQ-022 WAIT: timeout counter increments every clk; reaching TIMEOUT SHALL deassert eng_en, pulse err[winner], go to GAP, taking priority over a same-cycle finished.
REQ-023 GAP: SHALL clear gnt, record winner as last-granted, hold eng_en=0 for one full eng_tick period (two ticks), then go to IDLE.
REQ-024 eng_data and winner SHALL be stable from GRANT through GAP; req_data changes mid-transfer SHALL be ignored.
REQ-025 A requester dropping req mid-transfer SHALL NOT abort the transfer; done/err still pulses.
REQ-026 Simultaneous requests SHALL be served in rotating order; with all NREQ requesting continuously each SHALL be granted once per NREQ transfers; last-granted index wraps from NREQ-1 to 0.
REQ-027 done and err SHALL never pulse in the same cycle, and only for the granted index.
REQ-028 Retry counter width SHALL be clog2(RETRY_MAX+1); timeout counter width clog2(TIMEOUT+1); no wrap.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, gnt=0, done=0, err=0, eng_en=0, eng_data=0, busy=0, counters 0, last-granted=NREQ-1 (first grant favours index 0).
REQ-030 Reset mid-transfer SHALL drop eng_en at once; no done/err issued for the aborted transfer.

Structure
REQ-031 Shared package sccb_pkg SHALL hold the state encoding, SCCB word width (24), and NACK polarity constant.
REQ-032 Round-robin selection SHALL be one combinational sub-module rr_arbiter (inputs req, last index; output one-hot winner).

Verification
REQ-033 Single req[0], data 24'h72_12_80, engine ACKs -> gnt=001, eng_data=24'h721280, eng_en rises on a tick, done[0] one pulse, busy low after GAP.
REQ-034 req=111 held, all ACK -> grant order 0,1,2,0,1,2; six done pulses, no err.
REQ-035 req[1], engine NACKs 2 times then ACKs -> three eng_en assertions, done[1] once, err never.
REQ-036 req[2], engine always NACKs, RETRY_MAX=3 -> four eng_en assertions, err[2] once, then IDLE.
REQ-037 req[0], eng_finished never rises, TIMEOUT=200 -> eng_en drops at cycle 200 of WAIT, err[0] pulse.
REQ-038 rst_n low during WAIT -> eng_en, gnt, busy 0 asynchronously; no done/err; after release with req=011 grant goes to index 0.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write-engine arbiter: word width, ack polarity, FSM encoding.
package sccb_pkg;
  localparam int   SCCB_W = 24;
  localparam logic ACK_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after `last` wins, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win
);

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last) + off) % NREQ;
      if (!found && req[IW'(idx)]) begin
        win[IW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one SCCB write engine among NREQ requesters with round-robin grant, NACK retry and timeout.
//
// state | meaning
// IDLE  | no transfer; pick a winner when any req is high
// GRANT | winner latched, waiting for a bus tick
// ISSUE | raise eng_en on the next tick, restart timeout
// WAIT  | engine running; resolve ACK/NACK on tick or timeout
// GAP   | eng_en low for two ticks before the next grant
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [SCCB_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  input  logic                   eng_tick,
  output logic                   eng_en,
  output logic [SCCB_W-1:0]      eng_data,
  input  logic                   eng_finished,
  input  logic                   eng_ack,
  output logic                   busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t            state_q, state_d;
  logic [IW-1:0]     winner_q, winner_d, last_q, last_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              gap_q, gap_d;
  logic              eng_en_q, eng_en_d;
  logic [SCCB_W-1:0] data_q, data_d;
  logic [NREQ-1:0]   done_q, done_d, err_q, err_d;

  logic [NREQ-1:0]   win_oh, sel;
  logic [IW-1:0]     win_idx;
  logic [SCCB_W-1:0] win_data;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req  (req),
    .last (last_q),
    .win  (win_oh)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = IW'(i);
        win_data = req_data[i*SCCB_W +: SCCB_W];
      end
    end
  end

  assign sel = ONE << winner_q;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    eng_en_d = eng_en_q;
    data_d   = data_q;
    done_d   = '0;
    err_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          winner_d = win_idx;
          data_d   = win_data;
          retry_d  = '0;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (eng_tick) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (eng_tick) begin
          eng_en_d = 1'b1;
          tmo_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Timeout wins over a finished seen in the same cycle.
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          eng_en_d = 1'b0;
          err_d    = sel;
          gap_d    = 1'b0;
          state_d  = ST_GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (eng_tick && eng_finished) begin
            eng_en_d = 1'b0;
            if (eng_ack != ACK_NACK) begin
              done_d  = sel;
              gap_d   = 1'b0;
              state_d = ST_GAP;
            end else if (retry_q < RW'(RETRY_MAX)) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_ISSUE;
            end else begin
              err_d   = sel;
              gap_d   = 1'b0;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        last_d = winner_q;
        if (eng_tick) begin
          if (gap_q) state_d = ST_IDLE;
          else       gap_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      last_q   <= IW'(NREQ - 1);
      retry_q  <= '0;
      tmo_q    <= '0;
      gap_q    <= 1'b0;
      eng_en_q <= 1'b0;
      data_q   <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      eng_en_q <= eng_en_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign gnt      = (state_q == ST_GRANT || state_q == ST_ISSUE || state_q == ST_WAIT) ? sel : '0;
  assign done     = done_q;
  assign err      = err_q;
  assign eng_en   = eng_en_q;
  assign eng_data = data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
